// File: rtl/fwd_pipe_if.sv
// Bus between the EX-stage datapath and the EX/MEM, MEM/WB pipeline/forwarding unit.
interface fwd_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
);
  logic              stall_i;
  logic              flush_i;
  logic              ex_regwrite_i;
  logic              ex_memread_i;
  logic [REG_W-1:0]  ex_rd_i;
  logic [DATA_W-1:0] ex_result_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic [REG_W-1:0]  id_rs_i;
  logic [REG_W-1:0]  id_rt_i;

  logic [DATA_W-1:0] exmem_data_o;
  logic [REG_W-1:0]  exmem_rd_o;
  logic              exmem_regwrite_o;
  logic              exmem_memread_o;
  logic [DATA_W-1:0] wb_data_o;
  logic [REG_W-1:0]  wb_rd_o;
  logic              wb_regwrite_o;
  logic [1:0]        fwd_a_sel_o;
  logic [1:0]        fwd_b_sel_o;
  logic              load_use_o;

  // Datapath side: drives EX-stage info, consumes pipeline state and selects.
  modport master (
    output stall_i, flush_i, ex_regwrite_i, ex_memread_i, ex_rd_i, ex_result_i,
           mem_rdata_i, id_rs_i, id_rt_i,
    input  exmem_data_o, exmem_rd_o, exmem_regwrite_o, exmem_memread_o,
           wb_data_o, wb_rd_o, wb_regwrite_o, fwd_a_sel_o, fwd_b_sel_o, load_use_o
  );

  // Pipeline/forwarding unit side.
  modport slave (
    input  stall_i, flush_i, ex_regwrite_i, ex_memread_i, ex_rd_i, ex_result_i,
           mem_rdata_i, id_rs_i, id_rt_i,
    output exmem_data_o, exmem_rd_o, exmem_regwrite_o, exmem_memread_o,
           wb_data_o, wb_rd_o, wb_regwrite_o, fwd_a_sel_o, fwd_b_sel_o, load_use_o
  );
endinterface

// File: rtl/fwd_pipe_unit.sv
// EX/MEM and MEM/WB pipeline registers with EX-stage forwarding selects
// and load-use hazard detection.
module fwd_pipe_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic           clk_i,
  input  logic           rst_i,
  fwd_pipe_if.slave      bus
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_MEMWB = 2'b01;
  localparam logic [1:0] SEL_EXMEM = 2'b10;

  logic              exmem_regwrite_q;
  logic              exmem_memread_q;
  logic [REG_W-1:0]  exmem_rd_q;
  logic [DATA_W-1:0] exmem_data_q;
  logic              wb_regwrite_q;
  logic [REG_W-1:0]  wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;

  // Pipeline registers: stall holds both, flush bubbles EX/MEM only.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      exmem_regwrite_q <= 1'b0;
      exmem_memread_q  <= 1'b0;
      exmem_rd_q       <= '0;
      exmem_data_q     <= '0;
      wb_regwrite_q    <= 1'b0;
      wb_rd_q          <= '0;
      wb_data_q        <= '0;
    end else if (!bus.stall_i) begin
      wb_regwrite_q <= exmem_regwrite_q;
      wb_rd_q       <= exmem_rd_q;
      wb_data_q     <= exmem_memread_q ? bus.mem_rdata_i : exmem_data_q;
      if (bus.flush_i) begin
        exmem_regwrite_q <= 1'b0;
        exmem_memread_q  <= 1'b0;
        exmem_rd_q       <= '0;
        exmem_data_q     <= '0;
      end else begin
        exmem_regwrite_q <= bus.ex_regwrite_i;
        exmem_memread_q  <= bus.ex_memread_i;
        exmem_rd_q       <= bus.ex_rd_i;
        exmem_data_q     <= bus.ex_result_i;
      end
    end
  end

  logic exmem_wr_valid;
  logic wb_wr_valid;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       load_use;

  // A load in EX/MEM has no data yet, so it can never be the forwarding source.
  assign exmem_wr_valid = exmem_regwrite_q && (exmem_rd_q != '0) && !exmem_memread_q;
  assign wb_wr_valid    = wb_regwrite_q && (wb_rd_q != '0);

  always_comb begin
    fwd_a_sel = SEL_RF;
    fwd_b_sel = SEL_RF;
    load_use  = 1'b0;

    if (exmem_wr_valid && (exmem_rd_q == bus.id_rs_i)) begin
      fwd_a_sel = SEL_EXMEM;
    end else if (wb_wr_valid && (wb_rd_q == bus.id_rs_i)) begin
      fwd_a_sel = SEL_MEMWB;
    end

    if (exmem_wr_valid && (exmem_rd_q == bus.id_rt_i)) begin
      fwd_b_sel = SEL_EXMEM;
    end else if (wb_wr_valid && (wb_rd_q == bus.id_rt_i)) begin
      fwd_b_sel = SEL_MEMWB;
    end

    if (exmem_regwrite_q && exmem_memread_q && (exmem_rd_q != '0) &&
        ((exmem_rd_q == bus.id_rs_i) || (exmem_rd_q == bus.id_rt_i))) begin
      load_use = 1'b1;
    end
  end

  assign bus.exmem_data_o     = exmem_data_q;
  assign bus.exmem_rd_o       = exmem_rd_q;
  assign bus.exmem_regwrite_o = exmem_regwrite_q;
  assign bus.exmem_memread_o  = exmem_memread_q;
  assign bus.wb_data_o        = wb_data_q;
  assign bus.wb_rd_o          = wb_rd_q;
  assign bus.wb_regwrite_o    = wb_regwrite_q;
  assign bus.fwd_a_sel_o      = fwd_a_sel;
  assign bus.fwd_b_sel_o      = fwd_b_sel;
  assign bus.load_use_o       = load_use;

endmodule

// File: tb/tb_fwd_pipe_unit.sv
// Self-checking bench for fwd_pipe_unit: directed scenarios, then randomized
// traffic against a producer-list reference model.
module tb_fwd_pipe_unit;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef struct {
    logic        rw;
    logic        mr;
    logic [4:0]  rd;
    logic [31:0] d;
  } instr_t;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  // Reference: the instruction in EX/MEM and the one in MEM/WB (newest first).
  instr_t m_ex;
  instr_t m_wb;

  fwd_pipe_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  fwd_pipe_unit #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Newest in-flight producer of src wins; a load still in EX/MEM is not a source.
  function automatic logic [1:0] exp_sel(input logic [4:0] src);
    instr_t prod [2];
    prod[0] = m_ex;
    prod[1] = m_wb;
    for (int i = 0; i < 2; i++) begin
      if (prod[i].rw && prod[i].rd != 0 && prod[i].rd == src && !(i == 0 && prod[i].mr))
        return (i == 0) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic logic exp_load_use();
    return m_ex.rw && m_ex.mr && m_ex.rd != 0 &&
           (m_ex.rd == bus.id_rt_i || m_ex.rd == bus.id_rs_i);
  endfunction

  task automatic check_all();
    chk("exmem_data",  bus.exmem_data_o,     m_ex.d);
    chk("exmem_rd",    32'(bus.exmem_rd_o),  32'(m_ex.rd));
    chk("exmem_rw",    32'(bus.exmem_regwrite_o), 32'(m_ex.rw));
    chk("exmem_mr",    32'(bus.exmem_memread_o),  32'(m_ex.mr));
    chk("wb_data",     bus.wb_data_o,        m_wb.d);
    chk("wb_rd",       32'(bus.wb_rd_o),     32'(m_wb.rd));
    chk("wb_rw",       32'(bus.wb_regwrite_o), 32'(m_wb.rw));
    chk("fwd_a",       32'(bus.fwd_a_sel_o), 32'(exp_sel(bus.id_rs_i)));
    chk("fwd_b",       32'(bus.fwd_b_sel_o), 32'(exp_sel(bus.id_rt_i)));
    chk("load_use",    32'(bus.load_use_o),  32'(exp_load_use()));
  endtask

  // Check current outputs, then advance one clock and the model with it.
  task automatic cyc();
    instr_t n_ex;
    instr_t n_wb;
    #1;
    check_all();
    n_ex = m_ex;
    n_wb = m_wb;
    if (!rst) begin
      n_ex = '{0, 0, 0, 0};
      n_wb = '{0, 0, 0, 0};
    end else if (!bus.stall_i) begin
      n_wb = '{m_ex.rw, 1'b0, m_ex.rd, m_ex.mr ? bus.mem_rdata_i : m_ex.d};
      if (bus.flush_i) n_ex = '{0, 0, 0, 0};
      else n_ex = '{bus.ex_regwrite_i, bus.ex_memread_i, bus.ex_rd_i, bus.ex_result_i};
    end
    @(posedge clk);
    m_ex = n_ex;
    m_wb = n_wb;
    @(negedge clk);
  endtask

  task automatic set_ex(input logic rw, input logic mr, input logic [4:0] rd, input logic [31:0] d);
    bus.ex_regwrite_i = rw;
    bus.ex_memread_i  = mr;
    bus.ex_rd_i       = rd;
    bus.ex_result_i   = d;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    m_ex = '{0, 0, 0, 0};
    m_wb = '{0, 0, 0, 0};
    rst = 1'b0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    set_ex(1'b0, 1'b0, 5'd0, 32'd0);
    bus.mem_rdata_i = 32'd0;
    bus.id_rs_i = 5'd0;
    bus.id_rt_i = 5'd0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_exmem_rw", 32'(bus.exmem_regwrite_o), 32'd0);
    chk("rst_fwd_a",    32'(bus.fwd_a_sel_o), 32'd0);
    cyc();
    rst = 1'b1;

    // EX/MEM forwarding
    set_ex(1'b1, 1'b0, 5'd8, 32'h0000_1234);
    cyc();
    set_ex(1'b0, 1'b0, 5'd0, 32'd0);
    bus.id_rs_i = 5'd8;
    bus.id_rt_i = 5'd9;
    #1;
    chk("exfwd_a",    32'(bus.fwd_a_sel_o), 32'h2);
    chk("exfwd_b",    32'(bus.fwd_b_sel_o), 32'h0);
    chk("exfwd_data", bus.exmem_data_o, 32'h0000_1234);
    cyc();

    // Priority of the newer EX/MEM value over MEM/WB
    bus.id_rs_i = 5'd0;
    bus.id_rt_i = 5'd0;
    set_ex(1'b1, 1'b0, 5'd5, 32'h0000_AAAA);
    cyc();
    set_ex(1'b1, 1'b0, 5'd5, 32'h0000_BBBB);
    cyc();
    set_ex(1'b0, 1'b0, 5'd0, 32'd0);
    bus.id_rt_i = 5'd5;
    #1;
    chk("prio_b",    32'(bus.fwd_b_sel_o), 32'h2);
    chk("prio_data", bus.exmem_data_o, 32'h0000_BBBB);
    chk("prio_wb",   bus.wb_data_o, 32'h0000_AAAA);
    cyc();

    // Register 0 is never forwarded
    bus.id_rt_i = 5'd0;
    set_ex(1'b1, 1'b0, 5'd0, 32'h77);
    cyc();
    cyc();
    #1;
    chk("r0_a", 32'(bus.fwd_a_sel_o), 32'h0);
    chk("r0_b", 32'(bus.fwd_b_sel_o), 32'h0);
    cyc();

    // Load path: hazard while in EX/MEM, MEM/WB forwarding one cycle later
    set_ex(1'b1, 1'b1, 5'd4, 32'h5555);
    cyc();
    set_ex(1'b0, 1'b0, 5'd0, 32'd0);
    bus.mem_rdata_i = 32'hDEAD_BEEF;
    bus.id_rs_i = 5'd4;
    #1;
    chk("ld_use",   32'(bus.load_use_o), 32'h1);
    chk("ld_not10", 32'(bus.fwd_a_sel_o != 2'b10), 32'h1);
    cyc();
    bus.mem_rdata_i = 32'd0;
    #1;
    chk("ld_wb_data", bus.wb_data_o, 32'hDEAD_BEEF);
    chk("ld_fwd_a",   32'(bus.fwd_a_sel_o), 32'h1);
    chk("ld_no_use",  32'(bus.load_use_o), 32'h0);
    cyc();

    // Stall holds both registers, ignores flush; unstalled flush bubbles EX/MEM
    bus.id_rs_i = 5'd0;
    set_ex(1'b1, 1'b0, 5'd6, 32'h6666);
    cyc();
    set_ex(1'b1, 1'b0, 5'd7, 32'h7777);
    cyc();
    set_ex(1'b1, 1'b0, 5'd9, 32'h9999);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    #1;
    chk("stall_exmem", bus.exmem_data_o, 32'h7777);
    chk("stall_wb",    bus.wb_data_o, 32'h6666);
    bus.flush_i = 1'b1;
    cyc();
    #1;
    chk("stflush_rw", 32'(bus.exmem_regwrite_o), 32'h1);
    chk("stflush_rd", 32'(bus.exmem_rd_o), 32'h7);
    bus.stall_i = 1'b0;
    cyc();
    #1;
    chk("flush_rw", 32'(bus.exmem_regwrite_o), 32'h0);
    chk("flush_wb", bus.wb_data_o, 32'h7777);
    chk("flush_wbrd", 32'(bus.wb_rd_o), 32'h7);
    bus.flush_i = 1'b0;
    cyc();

    // Randomized traffic, with an asynchronous reset dropped mid-stream
    for (int n = 0; n < 400; n++) begin
      bus.stall_i = ($urandom_range(0, 4) == 0);
      bus.flush_i = ($urandom_range(0, 6) == 0);
      set_ex(1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      bus.mem_rdata_i = $urandom;
      bus.id_rs_i = 5'($urandom_range(0, 7));
      bus.id_rt_i = 5'($urandom_range(0, 7));
      if (n == 200) begin
        // Force known non-zero state first, then reset between edges.
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        set_ex(1'b1, 1'b0, 5'd3, 32'h1357_9BDF);
        cyc();
        rst = 1'b0;
        m_ex = '{0, 0, 0, 0};
        m_wb = '{0, 0, 0, 0};
        #1;
        chk("arst_exmem_data", bus.exmem_data_o, 32'd0);
        chk("arst_wb_data",    bus.wb_data_o, 32'd0);
        cyc();
        rst = 1'b1;
        set_ex(1'b1, 1'b0, 5'd2, 32'h2468_ACE0);
        cyc();
        #1;
        chk("arst_first_cap", bus.exmem_data_o, 32'h2468_ACE0);
      end else begin
        cyc();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fwd_pipe_unit.md
Name: fwd_pipe_unit

Overview:
- EX/MEM and MEM/WB pipeline registers for the pipelined CPU datapath, plus the forwarding-select logic for the EX-stage 3-to-1 operand muxes.
- Captures each EX-stage result and carries it through MEM to WB.
- Produces the two 2-bit selects and the two forwarded data values consumed by the ALU-operand muxes. Select encoding: 00 = register-file value, 01 = MEM/WB value, 10 = EX/MEM value.
- Also flags load-use hazards.

Parameters:
- DATA_W, 32, width of datapath values.
- REG_W, 5, width of register indices.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- stall_i  in  1  when 1, both pipeline registers hold.
- flush_i  in  1  when 1 and stall_i=0, a bubble enters EX/MEM.
- ex_regwrite_i  in  1  EX instruction writes a register.
- ex_memread_i  in  1  EX instruction is a load.
- ex_rd_i  in  REG_W  EX destination register.
- ex_result_i  in  DATA_W  EX ALU result.
- mem_rdata_i  in  DATA_W  data-memory read data for the instruction in EX/MEM.
- id_rs_i  in  REG_W  source register A of the instruction currently in EX.
- id_rt_i  in  REG_W  source register B of the instruction currently in EX.
- exmem_data_o  out  DATA_W  EX/MEM ALU result; forwarding input 10.
- exmem_rd_o  out  REG_W  EX/MEM destination.
- exmem_regwrite_o  out  1  EX/MEM write enable.
- exmem_memread_o  out  1  EX/MEM load flag.
- wb_data_o  out  DATA_W  MEM/WB write-back data; forwarding input 01.
- wb_rd_o  out  REG_W  MEM/WB destination.
- wb_regwrite_o  out  1  MEM/WB write enable to the register file.
- fwd_a_sel_o  out  2  select for the operand-A 3-to-1 mux.
- fwd_b_sel_o  out  2  select for the operand-B 3-to-1 mux.
- load_use_o  out  1  the operand needed in EX comes from a load still in EX/MEM.

Behaviour:
- Reset (rst_i=0, asynchronous, takes effect immediately): all registered outputs are 0. This makes fwd_a_sel_o = fwd_b_sel_o = 00 and load_use_o = 0. Reset mid-operation discards all in-flight state; first capture occurs on the first rising edge after rst_i returns to 1.
- Normal edge (stall_i=0, flush_i=0):
  - EX/MEM <= {ex_regwrite_i, ex_memread_i, ex_rd_i, ex_result_i}.
  - MEM/WB <= {exmem_regwrite_o, exmem_rd_o, exmem_memread_o ? mem_rdata_i : exmem_data_o}.
- Flush (stall_i=0, flush_i=1):
  - EX/MEM regwrite, memread and rd are cleared to 0; its data field is don't-care and is cleared to 0.
  - MEM/WB advances normally.
- Stall (stall_i=1): both registers hold, and flush_i is ignored.
- Latency: an EX result appears on exmem_* 1 cycle after capture and on wb_* 2 cycles after capture, absent stalls.
- Forward select for operand A (fwd_a_sel_o), combinational from the registered state and id_rs_i:
  - 10 if exmem_regwrite_o=1, exmem_rd_o != 0, exmem_rd_o == id_rs_i, and exmem_memread_o=0.
  - otherwise 01 if wb_regwrite_o=1, wb_rd_o != 0, and wb_rd_o == id_rs_i.
  - otherwise 00.
- Forward select for operand B (fwd_b_sel_o): identical rule using id_rt_i.
- Priority: EX/MEM (the newer value) always beats MEM/WB when both match.
- Register 0 is never forwarded.
- select 11 is never driven.
- load_use_o = 1 when exmem_regwrite_o=1, exmem_memread_o=1, exmem_rd_o != 0, and (exmem_rd_o == id_rs_i or exmem_rd_o == id_rt_i).
  - When load_use_o=1, the matching select falls through to the MEM/WB check or 00; it is never 10.
  - The upstream hazard controller uses load_use_o to drive stall_i.
- Write-back timing: the register-file write happens in the same cycle that wb_* is valid.
- Register-file write-through is the register file's responsibility, not this block's.

Test Plan:
- Reset: drive rst_i=0 mid-stream with non-zero state -> all outputs read 0 immediately, without waiting for a clock edge. After release, the first capture lands on the next edge.
- EX/MEM forwarding: capture regwrite=1, rd=8, result=0x0000_1234. Next cycle set id_rs_i=8, id_rt_i=9 -> fwd_a_sel_o=10, fwd_b_sel_o=00, exmem_data_o=0x1234.
- Priority: back-to-back writes to rd=5 with results 0xAAAA then 0xBBBB, id_rt_i=5 -> fwd_b_sel_o=10 with exmem_data_o=0xBBBB, not 01. Writes to rd=0 -> both selects stay 00.
- Load path: capture memread=1, rd=4, mem_rdata_i=0xDEAD_BEEF, id_rs_i=4 -> load_use_o=1 and fwd_a_sel_o != 10. One cycle later wb_data_o=0xDEADBEEF and fwd_a_sel_o=01.
- Stall/flush: stall_i=1 for 3 cycles -> exmem_* and wb_* hold. stall_i=1 with flush_i=1 -> no bubble. stall_i=0 with flush_i=1 -> exmem_regwrite_o=0 next cycle, while wb_* advances the previous EX/MEM content.
